lza_pipe: RTL and testbench
===========================

LZA_PIPE -- requirements
Module: lza_pipe

Interface
REQ-001 Parameter WIDTH, default 107: operand width; legal range 4..256.
REQ-002 Parameter TAG_W, default 8: width of the sideband tag carried alongside each operand pair.
REQ-003 Derived CNT_W = ceil(log2(WIDTH+1)): width of the count output.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 in_valid  input  1  operand pair present.
REQ-007 in_ready  output  1  block accepts an operand pair this cycle.
REQ-008 in_a  input  WIDTH  first addend.
REQ-009 in_b  input  WIDTH  second addend.
REQ-010 in_tag  input  TAG_W  sideband; returned unchanged with the result.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts the result this cycle.
REQ-013 zero_cnt  output  CNT_W  anticipated leading-zero count.
REQ-014 invalid  output  1  indicator vector is all zero.
REQ-015 out_tag  output  TAG_W  tag of the current result.

Function
REQ-016 Per-bit terms: T = a^b; G = a&b; Z = ~a&~b.
REQ-017 Indicator bit f[WIDTH-1] = ~T[WIDTH-1] & T[WIDTH-2].
REQ-018 For 1 <= i <= WIDTH-2: f[i] = T[i+1]&((G[i]&~Z[i-1])|(Z[i]&~G[i-1])) | ~T[i+1]&((Z[i]&~Z[i-1])|(G[i]&~G[i-1])).
REQ-019 f[0] = T[1]&Z[0] | ~T[1]&G[0]; this equals REQ-018 evaluated with virtual bit -1 having G=0 and Z=1, so every bit of f is driven.
REQ-020 zero_cnt = number of consecutive zeros in f counted from f[WIDTH-1] downward; invalid = 0 when f is non-zero.
REQ-021 When f == 0: zero_cnt = WIDTH and invalid = 1.
REQ-022 The count is exact for every WIDTH in range; it does not depend on WIDTH being a power of two, and no padding bits are counted.
REQ-023 Stage 1 registers f and the tag; stage 2 registers zero_cnt, invalid and the tag. Each stage has a valid bit, v1 and v2.
REQ-024 Latency: a pair accepted in cycle N appears on out_valid in cycle N+2 when out_ready is held high.
REQ-025 Throughput: one pair per cycle while out_ready = 1.
REQ-026 adv2 = ~v2 | out_ready. Stage 2 loads from stage 1 when adv2 is 1; v2 then takes the value of v1.
REQ-027 adv1 = ~v1 | adv2. Stage 1 loads from the inputs when adv1 is 1; v1 then takes the value of in_valid.
REQ-028 in_ready = adv1. It is combinational from out_ready and the stage valid bits, never from in_valid.
REQ-029 A pair transfers on in_valid & in_ready; a result transfers on out_valid & out_ready.
REQ-030 out_valid = v2. zero_cnt, invalid and out_tag are driven directly from stage-2 registers.
REQ-031 Stall: while out_valid = 1 and out_ready = 0, the stage-2 outputs hold stable; stage 1 holds when full.
REQ-032 With both stages full and stalled, in_ready = 0.
REQ-033 Simultaneous transfer: an output transfer and an input transfer in the same cycle both complete, with no bubble and no loss.
REQ-034 Results leave in acceptance order; no pair is dropped or duplicated.
REQ-035 Data registers may load while their stage valid bit is 0; their contents are don't-care when invalid.

Reset
REQ-036 When rst_n = 0 at a rising clk edge: v1 = 0, v2 = 0, zero_cnt = 0, invalid = 0, out_tag = 0.
REQ-037 While rst_n = 0: in_ready = 0 and out_valid = 0.
REQ-038 Reset asserted mid-operation discards all in-flight pairs.
REQ-039 The first cycle after release has in_ready = 1.

Verification (WIDTH=8 unless noted)
REQ-040 a=0x01, b=0x00, tag=0x11, out_ready=1 -> two cycles later: out_valid=1, zero_cnt=6, invalid=0, out_tag=0x11.
REQ-041 a=0x40, b=0x00 -> zero_cnt=0, invalid=0; a=0x00, b=0x00 -> zero_cnt=8, invalid=1.
REQ-042 Back-to-back stream of 16 tagged pairs, out_ready=1 -> 16 results in consecutive cycles, in order, each matching a reference model of REQ-016..021.
REQ-043 out_ready=0 for 5 cycles with a stream pending -> in_ready falls after 2 accepts, outputs are stable throughout, and no loss or duplication occurs on release.
REQ-044 rst_n pulsed low while both stages are valid -> next cycle out_valid=0 and in_ready=1, and no stale result ever appears.
REQ-045 WIDTH=107, random and corner operands (all-ones plus 1, alternating bits, single set bits) -> results match the model, including zero_cnt=107 with invalid=1 for a=b=0.

Source files
------------

// File: rtl/lza_pipe_if.sv
// Operand/result handshake bundle for the leading-zero anticipator pipeline.
// The producer/consumer side uses master; the pipeline uses slave.
interface lza_pipe_if #(
  parameter int WIDTH = 107,
  parameter int TAG_W = 8
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] zero_cnt;
  logic             invalid;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, zero_cnt, invalid, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, zero_cnt, invalid, out_tag
  );
endinterface

// File: rtl/lza_pipe.sv
// Two-stage leading-zero anticipator: stage 1 registers the indicator vector,
// stage 2 registers its leading-zero count; elastic valid/ready between stages.
module lza_pipe #(
  parameter int WIDTH = 107,
  parameter int TAG_W = 8
) (
  input logic         clk,
  input logic         rst_n,
  lza_pipe_if.slave   bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  // Only the bit ranges each indicator term actually reads are kept.
  logic [WIDTH-1:1] w_t;
  logic [WIDTH-2:0] w_g;
  logic [WIDTH-2:0] w_z;
  logic [WIDTH-1:0] w_f;

  assign w_t = bus.in_a[WIDTH-1:1] ^ bus.in_b[WIDTH-1:1];
  assign w_g = bus.in_a[WIDTH-2:0] & bus.in_b[WIDTH-2:0];
  assign w_z = ~bus.in_a[WIDTH-2:0] & ~bus.in_b[WIDTH-2:0];

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ind
      if (gi == WIDTH - 1) begin : g_top
        assign w_f[gi] = ~w_t[gi] & w_t[gi-1];
      end else begin : g_body
        logic w_g_lo;
        logic w_z_lo;
        // Bit 0 sees a virtual lower neighbour with G=0, Z=1.
        if (gi == 0) begin : g_lsb
          assign w_g_lo = 1'b0;
          assign w_z_lo = 1'b1;
        end else begin : g_mid
          assign w_g_lo = w_g[gi-1];
          assign w_z_lo = w_z[gi-1];
        end
        assign w_f[gi] = (w_t[gi+1] & ((w_g[gi] & ~w_z_lo) | (w_z[gi] & ~w_g_lo)))
                       | (~w_t[gi+1] & ((w_z[gi] & ~w_z_lo) | (w_g[gi] & ~w_g_lo)));
      end
    end
  endgenerate

  logic             r_v1;
  logic [WIDTH-1:0] r_f;
  logic [TAG_W-1:0] r_tag1;
  logic             r_v2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_inv;
  logic [TAG_W-1:0] r_tag2;

  logic             w_adv1;
  logic             w_adv2;
  logic [CNT_W-1:0] w_cnt;
  logic             w_inv;

  assign w_adv2 = ~r_v2 | bus.out_ready;
  assign w_adv1 = ~r_v1 | w_adv2;

  // Ascending scan: the highest set bit writes last and wins.
  always_comb begin
    w_cnt = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (r_f[i]) w_cnt = CNT_W'(WIDTH - 1 - i);
    end
  end
  assign w_inv = ~|r_f;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v1   <= 1'b0;
      r_f    <= '0;
      r_tag1 <= '0;
      r_v2   <= 1'b0;
      r_cnt  <= '0;
      r_inv  <= 1'b0;
      r_tag2 <= '0;
    end else begin
      if (w_adv1) begin
        r_v1   <= bus.in_valid;
        r_f    <= w_f;
        r_tag1 <= bus.in_tag;
      end
      if (w_adv2) begin
        r_v2   <= r_v1;
        r_cnt  <= w_cnt;
        r_inv  <= w_inv;
        r_tag2 <= r_tag1;
      end
    end
  end

  assign bus.in_ready  = w_adv1 & rst_n;
  assign bus.out_valid = r_v2 & rst_n;
  assign bus.zero_cnt  = r_cnt;
  assign bus.invalid   = r_inv;
  assign bus.out_tag   = r_tag2;
endmodule

// File: tb/tb_lza_pipe.sv
// Directed bench for lza_pipe at WIDTH=8 and WIDTH=107 with a per-pair scoreboard.
module tb_lza_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lza_pipe_if #(.WIDTH(8),   .TAG_W(8)) b8 ();
  lza_pipe_if #(.WIDTH(107), .TAG_W(8)) bw ();

  lza_pipe #(.WIDTH(8),   .TAG_W(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  lza_pipe #(.WIDTH(107), .TAG_W(8)) uw (.clk(clk), .rst_n(rst_n), .bus(bw));

  typedef struct {
    int         cnt;
    bit         inv;
    logic [7:0] tag;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  // Indicator vector built straight from the per-bit G/T/Z definitions.
  function automatic int ref_lzc(input int w, input logic [255:0] a, input logic [255:0] b);
    logic [255:0] t, g, z, f;
    logic glo, zlo;
    t = a ^ b;
    g = a & b;
    z = ~a & ~b;
    f = '0;
    f[w-1] = ~t[w-1] & t[w-2];
    for (int i = 0; i < w - 1; i++) begin
      if (i == 0) begin
        glo = 1'b0;
        zlo = 1'b1;
      end else begin
        glo = g[i-1];
        zlo = z[i-1];
      end
      f[i] = t[i+1] ? ((g[i] & ~zlo) | (z[i] & ~glo)) : ((z[i] & ~zlo) | (g[i] & ~glo));
    end
    for (int i = w - 1; i >= 0; i--) begin
      if (f[i]) return w - 1 - i;
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    checks++;
    if (b8.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 0", b8.in_ready);
    end
    checks++;
    if (b8.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b expected 0", b8.out_valid);
    end
    checks++;
    if ({b8.zero_cnt, b8.invalid, b8.out_tag} !== 13'h0) begin
      errors++;
      $display("FAIL reset_outputs: got cnt=%0d inv=%b tag=%h expected 0/0/00",
               b8.zero_cnt, b8.invalid, b8.out_tag);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (b8.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_in_ready: got %b expected 1", b8.in_ready);
    end
  endtask

  task automatic test_basic();
    logic [7:0] va[5] = '{8'h01, 8'h40, 8'h00, 8'h80, 8'h0f};
    logic [7:0] vb[5] = '{8'h00, 8'h00, 8'h00, 8'h80, 8'h01};
    logic [7:0] vt[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    int         vc[5] = '{6, 0, 8, 8, 3};
    bit         vi[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    b8.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      b8.in_valid = 1'b1;
      b8.in_a = va[k];
      b8.in_b = vb[k];
      b8.in_tag = vt[k];
      #1;
      checks++;
      if (b8.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL basic_in_ready[%0d]: got %b expected 1", k, b8.in_ready);
      end
      tick();
      b8.in_valid = 1'b0;
      checks++;
      if (b8.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL basic_early[%0d]: out_valid got %b expected 0", k, b8.out_valid);
      end
      tick();
      checks++;
      if ({b8.out_valid, b8.zero_cnt, b8.invalid, b8.out_tag} !== {1'b1, 4'(vc[k]), vi[k], vt[k]}) begin
        errors++;
        $display("FAIL basic[%0d]: got v=%b cnt=%0d inv=%b tag=%h expected v=1 cnt=%0d inv=%b tag=%h",
                 k, b8.out_valid, b8.zero_cnt, b8.invalid, b8.out_tag, vc[k], vi[k], vt[k]);
      end
      $display("basic[%0d] a=%h b=%h -> cnt=%0d inv=%b tag=%h", k, va[k], vb[k],
               b8.zero_cnt, b8.invalid, b8.out_tag);
    end
  endtask

  task automatic test_back_to_back();
    int   sent = 0;
    int   recv = 0;
    int   first = -1;
    int   last = -1;
    exp_t e;
    b8.out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && recv < 16; cyc++) begin
      tick();
      b8.in_valid = (sent < 16);
      b8.in_a = 8'(sent * 37 + 5);
      b8.in_b = 8'((sent * 91) ^ 8'h5a);
      b8.in_tag = 8'(8'ha0 + sent);
      #1;
      checks++;
      if (b8.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_in_ready cyc %0d: got %b expected 1", cyc, b8.in_ready);
      end
      if (b8.out_valid === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra: got result tag=%h expected none", b8.out_tag);
        end else begin
          e = q.pop_front();
          if ({b8.zero_cnt, b8.invalid, b8.out_tag} !== {4'(e.cnt), e.inv, e.tag}) begin
            errors++;
            $display("FAIL b2b_result: got cnt=%0d inv=%b tag=%h expected cnt=%0d inv=%b tag=%h",
                     b8.zero_cnt, b8.invalid, b8.out_tag, e.cnt, e.inv, e.tag);
          end
          $display("b2b out tag=%h cnt=%0d inv=%b", b8.out_tag, b8.zero_cnt, b8.invalid);
        end
        recv++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (b8.in_valid && b8.in_ready) begin
        e.cnt = ref_lzc(8, 256'(b8.in_a), 256'(b8.in_b));
        e.inv = (e.cnt == 8);
        e.tag = b8.in_tag;
        q.push_back(e);
        sent++;
      end
    end
    b8.in_valid = 1'b0;
    checks++;
    if (recv != 16) begin
      errors++;
      $display("FAIL b2b_count: got %0d results expected 16", recv);
    end
    checks++;
    if (last - first != 15) begin
      errors++;
      $display("FAIL b2b_spacing: got span %0d cycles expected 15", last - first);
    end
  endtask

  task automatic test_stall();
    int         sent = 0;
    int         recv = 0;
    logic [13:0] snap = '0;
    exp_t       e;
    for (int cyc = 0; cyc < 60 && recv < 6; cyc++) begin
      tick();
      b8.out_ready = (cyc >= 5);
      b8.in_valid = (sent < 6);
      b8.in_a = 8'(sent * 53 + 17);
      b8.in_b = 8'(sent * 29);
      b8.in_tag = 8'(8'hc0 + sent);
      #1;
      if (cyc < 5) begin
        checks++;
        if (b8.in_ready !== (cyc < 2)) begin
          errors++;
          $display("FAIL stall_in_ready cyc %0d: got %b expected %b", cyc, b8.in_ready, cyc < 2);
        end
      end
      if (cyc == 2) begin
        snap = {b8.out_valid, b8.zero_cnt, b8.invalid, b8.out_tag};
        checks++;
        if (b8.out_valid !== 1'b1) begin
          errors++;
          $display("FAIL stall_full: out_valid got %b expected 1", b8.out_valid);
        end
      end
      if (cyc == 3 || cyc == 4) begin
        checks++;
        if ({b8.out_valid, b8.zero_cnt, b8.invalid, b8.out_tag} !== snap) begin
          errors++;
          $display("FAIL stall_hold cyc %0d: got %h expected %h", cyc,
                   {b8.out_valid, b8.zero_cnt, b8.invalid, b8.out_tag}, snap);
        end
      end
      if (b8.out_valid === 1'b1 && b8.out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL stall_extra: got result tag=%h expected none", b8.out_tag);
        end else begin
          e = q.pop_front();
          if ({b8.zero_cnt, b8.invalid, b8.out_tag} !== {4'(e.cnt), e.inv, e.tag}) begin
            errors++;
            $display("FAIL stall_result: got cnt=%0d inv=%b tag=%h expected cnt=%0d inv=%b tag=%h",
                     b8.zero_cnt, b8.invalid, b8.out_tag, e.cnt, e.inv, e.tag);
          end
          $display("stall out tag=%h cnt=%0d inv=%b", b8.out_tag, b8.zero_cnt, b8.invalid);
        end
        recv++;
      end
      if (b8.in_valid && b8.in_ready) begin
        e.cnt = ref_lzc(8, 256'(b8.in_a), 256'(b8.in_b));
        e.inv = (e.cnt == 8);
        e.tag = b8.in_tag;
        q.push_back(e);
        sent++;
      end
    end
    b8.in_valid = 1'b0;
    checks++;
    if (recv != 6 || q.size() != 0) begin
      errors++;
      $display("FAIL stall_count: got %0d results, %0d pending expected 6, 0", recv, q.size());
    end
  endtask

  task automatic test_reset_mid();
    b8.out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      b8.in_valid = 1'b1;
      b8.in_a = 8'h01;
      b8.in_b = 8'h00;
      b8.in_tag = 8'(8'he1 + k);
    end
    tick();
    b8.in_valid = 1'b0;
    checks++;
    if ({b8.out_valid, b8.in_ready} !== 2'b10) begin
      errors++;
      $display("FAIL mid_full: got v=%b rdy=%b expected v=1 rdy=0", b8.out_valid, b8.in_ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({b8.out_valid, b8.in_ready} !== 2'b00) begin
      errors++;
      $display("FAIL mid_in_reset: got v=%b rdy=%b expected v=0 rdy=0", b8.out_valid, b8.in_ready);
    end
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if ({b8.out_valid, b8.in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL mid_release: got v=%b rdy=%b expected v=0 rdy=1", b8.out_valid, b8.in_ready);
    end
    b8.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (b8.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_stale cyc %0d: out_valid got %b tag=%h expected 0", k, b8.out_valid, b8.out_tag);
      end
    end
    $display("reset_mid done");
  endtask

  task automatic test_width107();
    logic [106:0] va[$];
    logic [106:0] vb[$];
    int           hc[$];
    logic [106:0] alt = '0;
    int           sent = 0;
    int           recv = 0;
    exp_t         e;
    for (int i = 0; i < 107; i += 2) alt[i] = 1'b1;
    va.push_back('1);   vb.push_back(107'd1); hc.push_back(107);
    va.push_back('0);   vb.push_back('0);     hc.push_back(107);
    va.push_back(alt);  vb.push_back(~alt);   hc.push_back(107);
    va.push_back(alt);  vb.push_back(alt);    hc.push_back(-1);
    va.push_back(~alt); vb.push_back(alt>>1); hc.push_back(-1);
    va.push_back(107'd1); vb.push_back('0);   hc.push_back(105);
    va.push_back(107'd1 << 105); vb.push_back('0); hc.push_back(0);
    va.push_back(107'd1 << 106); vb.push_back('0); hc.push_back(1);
    va.push_back(107'd1 << 50);  vb.push_back('0); hc.push_back(-1);
    for (int k = 0; k < 6; k++) begin
      va.push_back(107'({$urandom(), $urandom(), $urandom(), $urandom()}));
      vb.push_back(107'({$urandom(), $urandom(), $urandom(), $urandom()}));
      hc.push_back(-1);
    end
    bw.out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && recv < va.size(); cyc++) begin
      tick();
      bw.in_valid = (sent < va.size());
      if (sent < va.size()) begin
        bw.in_a = va[sent];
        bw.in_b = vb[sent];
      end
      bw.in_tag = 8'(8'h70 + sent);
      #1;
      if (bw.out_valid === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL w107_extra: got result tag=%h expected none", bw.out_tag);
        end else begin
          e = q.pop_front();
          if ({bw.zero_cnt, bw.invalid, bw.out_tag} !== {7'(e.cnt), e.inv, e.tag}) begin
            errors++;
            $display("FAIL w107_result: got cnt=%0d inv=%b tag=%h expected cnt=%0d inv=%b tag=%h",
                     bw.zero_cnt, bw.invalid, bw.out_tag, e.cnt, e.inv, e.tag);
          end
          $display("w107 out tag=%h cnt=%0d inv=%b", bw.out_tag, bw.zero_cnt, bw.invalid);
        end
        recv++;
      end
      if (bw.in_valid && bw.in_ready) begin
        e.cnt = (hc[sent] >= 0) ? hc[sent] : ref_lzc(107, 256'(bw.in_a), 256'(bw.in_b));
        e.inv = (e.cnt == 107);
        e.tag = bw.in_tag;
        q.push_back(e);
        sent++;
      end
    end
    bw.in_valid = 1'b0;
    checks++;
    if (recv != va.size()) begin
      errors++;
      $display("FAIL w107_count: got %0d results expected %0d", recv, va.size());
    end
  endtask

  initial begin
    b8.in_valid = 1'b0; b8.in_a = '0; b8.in_b = '0; b8.in_tag = '0; b8.out_ready = 1'b0;
    bw.in_valid = 1'b0; bw.in_a = '0; bw.in_b = '0; bw.in_tag = '0; bw.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    q.delete();
    test_width107();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
